// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving an external 1-bit full adder, LSB first.
// Optional `SERIAL_ADD_SUB_EN adds a sub input for two's-complement subtraction.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic [WIDTH-1:0] sum_nxt;

    // Subtraction is a + ~b + 1: invert b once at capture and seed the carry.
    always_comb begin
        b_cap = b;
        c_cap = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_cap = ~b;
            c_cap = 1'b1;
        end
`endif
    end

    // Newest sum bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign sum_nxt = {fa_s, sum_sh};

    assign fa_a      = (state == RUN) & a_sh[0];
    assign fa_b      = (state == RUN) & b_sh[0];
    assign fa_cin    = (state == RUN) & carry;
    assign state_dbg = state;

    // Handshake: start is accepted on any edge where busy=0 (IDLE or the DONE
    // cycle); while busy=1 start is ignored. done is a one-cycle result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_cap;
                        carry <= c_cap;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt[WIDTH-1:1];
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= sum_nxt;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that sequences the lab's single 1-bit full adder (A, B, Cin -> S, Cout) over WIDTH clock cycles to add two WIDTH-bit operands. It holds the operands, drives the external full adder one bit per cycle (LSB first), and registers the carry between bits. It collects the sum bits and reports completion with a one-cycle done pulse. The full adder itself stays a separate instance; this block owns only sequencing and state.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  initial carry, captured on accepted start
fa_a  output  1  to full adder A
fa_b  output  1  to full adder B
fa_cin  output  1  to full adder Cin
fa_s  input  1  from full adder S
fa_cout  input  1  from full adder Cout
busy  output  1  high while addition in progress
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry, held with sum

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, counter=0, carry reg=0, operand shift regs=0; fa_a/fa_b/fa_cin=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> capture a, b into shift regs, carry<=cin, counter<=0, go RUN. start=0 -> stay.
- RUN: busy=1. fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry (combinational from regs). Each edge: sum_sh<={fa_s, sum_sh[WIDTH-1:1]}, carry<=fa_cout, a_sh/b_sh shift right, counter+1. On edge where counter==WIDTH-1 -> go DONE.
- DONE: done=1 and busy=0 for exactly one cycle; sum=sum_sh, cout=carry valid from this cycle. Next edge -> IDLE (or RUN if start=1, same capture as IDLE).
- Latency: start accepted at edge 0; bits processed at edges 1..WIDTH; done high in the cycle after edge WIDTH (WIDTH+1 cycles start-to-done).
- fa_* outputs are 0 outside RUN.
- start while busy=1: ignored, no capture, no effect on in-flight operation.
- a/b/cin changing during RUN: no effect (captured copies used).
- sum/cout update only at entry to DONE; stable in IDLE.
- Full adder assumed combinational; no wait states.
- rst_n asserted mid-RUN: immediate return to reset values; no done pulse; partial result discarded.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2**(WIDTH+1).

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: extra input port sub (1 bit), captured with operands. sub=1 -> b captured inverted and carry initialised to 1 (cin ignored), giving sum = a - b mod 2**WIDTH; cout=1 means no borrow (a>=b). sub=0 -> identical to base add.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulse -> busy for 8 cycles, done in cycle 9 after start, sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Start a=8'h12, b=8'h34; at cycle 3 pulse start with a=8'hFF, b=8'hFF -> second start ignored, sum=8'h46, cout=0, single done pulse.
- Start a=8'hAA, b=8'h55; drop rst_n at cycle 4 -> busy=0, sum=0, cout=0 immediately, no done; new start after release yields correct sum 8'hFF.
- Back-to-back: start held high in DONE cycle -> second operation starts without IDLE cycle; sum holds first result until second done.
- SERIAL_ADD_SUB_EN: a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, cout=1; a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, cout=0.
